// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM burst command scheduler:
// scheduler state encoding, default widths and the per-beat address step.
package sdram_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LEN_W  = 8;

  // Byte address advance per beat for the default beat width.
  localparam int BEAT_STEP = DEF_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_e;

  // Byte address advance per beat for an arbitrary beat width.
  function automatic int beat_step(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sdram_rd_hold.sv
// One-entry read return buffer. The command port returns data the cycle
// after a read issue; that beat is presented on r_* straight away, and is
// parked in a register if the consumer is not ready, so it stays stable
// until r_ready.
module sdram_rd_hold #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              issue,
  input  logic              issue_last,
  input  logic [DATA_W-1:0] rdata,
  input  logic              r_ready,
  output logic              r_valid,
  output logic [DATA_W-1:0] r_data,
  output logic              r_last
);

  logic              pend_q;
  logic              pend_last_q;
  logic              hold_q;
  logic              hold_last_q;
  logic [DATA_W-1:0] hold_data_q;

  // Track the beat arriving this cycle and park it when it is not consumed.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      hold_q      <= 1'b0;
      hold_last_q <= 1'b0;
      // NOTE: the data register is reset as well, so r_data is a known 0
      // out of reset instead of whatever the flops powered up with.
      hold_data_q <= '0;
    end else begin
      pend_q      <= issue;
      pend_last_q <= issue_last;
      if (pend_q && !r_ready) begin
        hold_q      <= 1'b1;
        hold_data_q <= rdata;
        hold_last_q <= pend_last_q;
      end else if (hold_q && r_ready) begin
        hold_q <= 1'b0;
      end
    end
  end

  // The scheduler never issues while a beat is held and unconsumed, so a
  // pending beat and a held beat never coexist.
  assign r_valid = pend_q | hold_q;
  assign r_data  = hold_q ? hold_data_q : (pend_q ? rdata : '0);
  assign r_last  = hold_q ? hold_last_q : (pend_q & pend_last_q);

endmodule

// File: rtl/sdram_cmd_sched.sv
// Burst command scheduler: arbitrates one read and one write burst
// requester and expands each accepted burst into single-beat commands.
// Optional build macro SDRAM_SCHED_PERF_EN adds saturating performance
// counters (perf_rd_beats, perf_wr_beats, perf_stall).
module sdram_cmd_sched
  import sdram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ar_valid,
  output logic              ar_ready,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic [LEN_W-1:0]  ar_len,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [DATA_W-1:0] r_data,
  output logic              r_last,
  input  logic              aw_valid,
  output logic              aw_ready,
  input  logic [ADDR_W-1:0] aw_addr,
  input  logic [LEN_W-1:0]  aw_len,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data,
  output logic              wr_done,
  output logic              cmd_valid,
  output logic              cmd_wen,
  output logic [31:0]       cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  input  logic [DATA_W-1:0] cmd_rdata
`ifdef SDRAM_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_rd_beats,
  output logic [31:0]       perf_wr_beats,
  output logic [31:0]       perf_stall
`endif
);

  localparam int STEP = beat_step(DATA_W);
  // Clears the sub-beat address bits so every command is beat aligned.
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~(ADDR_W'(STEP - 1));

  state_e            state_q;
  state_e            state_d;
  logic              last_wr_q;   // 1: the previous grant went to the writer
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              grant_rd;
  logic              grant_wr;
  logic              rd_issue;
  logic              wr_issue;

  // Next state, grants and command outputs for the current cycle.
  // NOTE: every output of this block is given a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    ar_ready  = 1'b0;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    cmd_valid = 1'b0;
    cmd_wen   = 1'b0;
    cmd_wdata = '0;
    wr_done   = 1'b0;
    rd_issue  = 1'b0;
    wr_issue  = 1'b0;
    // A tie goes to whichever side was not granted last time.
    grant_rd  = (state_q == IDLE) && ar_valid && (!aw_valid || last_wr_q);
    grant_wr  = (state_q == IDLE) && aw_valid && !grant_rd;
    case (state_q)
      IDLE: begin
        ar_ready = grant_rd;
        aw_ready = grant_wr;
        if (grant_rd)      state_d = READ;
        else if (grant_wr) state_d = WRITE;
      end
      READ: begin
        // Issue only when the return buffer is free or being drained now.
        rd_issue  = !r_valid || r_ready;
        cmd_valid = rd_issue;
        if (rd_issue && cnt_q == '0) state_d = IDLE;
      end
      WRITE: begin
        wr_issue  = w_valid;
        w_ready   = w_valid;
        cmd_valid = w_valid;
        cmd_wen   = w_valid;
        cmd_wdata = w_data;
        if (w_valid && cnt_q == '0) begin
          wr_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus the burst address/beat counter datapath.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b1;
      addr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (grant_rd || grant_wr) begin
        addr_q    <= (grant_rd ? ar_addr : aw_addr) & ADDR_MASK;
        cnt_q     <= grant_rd ? ar_len : aw_len;
        last_wr_q <= grant_wr;
      end else if (rd_issue || wr_issue) begin
        addr_q <= addr_q + ADDR_W'(STEP);   // wraps modulo 2^ADDR_W
        cnt_q  <= cnt_q - LEN_W'(1);
      end
    end
  end

  assign cmd_addr = 32'(addr_q);

  sdram_rd_hold #(.DATA_W(DATA_W)) u_rd_hold (
    .clock      (clock),
    .reset_n    (reset_n),
    .issue      (rd_issue),
    .issue_last (cnt_q == '0),
    .rdata      (cmd_rdata),
    .r_ready    (r_ready),
    .r_valid    (r_valid),
    .r_data     (r_data),
    .r_last     (r_last)
  );

`ifdef SDRAM_SCHED_PERF_EN
  logic stall_ev;
  assign stall_ev = (state_q == READ && !rd_issue) || (state_q == WRITE && !w_valid);

  // Saturating beat and stall counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_rd_beats <= '0;
      perf_wr_beats <= '0;
      perf_stall    <= '0;
    end else begin
      if (rd_issue && perf_rd_beats != '1) perf_rd_beats <= perf_rd_beats + 32'd1;
      if (wr_issue && perf_wr_beats != '1) perf_wr_beats <= perf_wr_beats + 32'd1;
      if (stall_ev && perf_stall    != '1) perf_stall    <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
